fetch_queue_unit: RTL and testbench

Instruction fetch front-end that drives the synchronous instruction memory and feeds the decode stage through a small prefetch FIFO. It holds the PC, issues at most one word request per cycle, and buffers returned words with their PCs. A valid/ready handshake lets decode stall without dropping instructions. A redirect port flushes the queue and restarts fetch at a new PC.

---
 rtl/fetch_queue_unit_pkg.sv | 13 +
 rtl/fetch_queue_unit_fetch_fifo.sv | 53 +++++
 rtl/fetch_queue_unit.sv | 85 ++++++++
 tb/tb_fetch_queue_unit.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_unit_pkg.sv
// Shared fetch front-end types and constants.
// One fetch entry pairs an instruction word with the PC it was fetched from.
package fetch_queue_unit_pkg;
    localparam int          XLEN             = 32;
    localparam int          INSTR_BYTES      = 4;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_queue_unit_fetch_fifo.sv
// Generic DEPTH-entry synchronous FIFO with flush; head reads as zero when empty.
// Push lands at the edge, so an entry is visible the cycle after its push.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign valid   = (count != '0);
    assign do_pop  = pop && valid && !flush;
    assign do_push = push && !flush && ((count != CW'(DEPTH)) || do_pop);
    assign head    = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Pointers wrap naturally since DEPTH is a power of two.
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/fetch_queue_unit.sv
// Fetch front-end: owns the PC, issues one imem request per cycle while credit lasts.
// Latency: request in cycle N is visible to decode in N+2. Decode stalls via out_ready.
module fetch_queue_unit #(
    parameter int              XLEN     = fetch_queue_unit_pkg::XLEN,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] PC_RESET = fetch_queue_unit_pkg::PC_RESET_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   imem_req,
    output logic [XLEN-1:0]        imem_addr,
    input  logic [XLEN-1:0]        imem_rdata,
    input  logic                   redirect_valid,
    input  logic [XLEN-1:0]        redirect_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [XLEN-1:0]        out_instr,
    output logic [XLEN-1:0]        out_pc,
    output logic [$clog2(DEPTH):0] occupancy
);
    import fetch_queue_unit_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] req_pc;
    logic            run;
    logic            inflight;
    logic            killed;
    logic            credit;
    logic            push;
    logic            pop;
    fetch_entry_t    push_entry;
    fetch_entry_t    head_entry;

    // Every in-flight request owns a FIFO slot, so the queue can never overflow.
    assign credit     = ({1'b0, occupancy} + {{CW{1'b0}}, inflight}) < (CW+1)'(DEPTH);
    assign imem_req   = run && !redirect_valid && credit;
    assign imem_addr  = pc;
    assign pop        = out_valid && out_ready;
    assign push       = inflight && !killed && !redirect_valid;
    assign push_entry = '{instr: imem_rdata, pc: req_pc};
    assign out_instr  = head_entry.instr;
    assign out_pc     = head_entry.pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc       <= PC_RESET;
            req_pc   <= PC_RESET;
            run      <= 1'b0;
            inflight <= 1'b0;
            killed   <= 1'b0;
        end else begin
            run <= 1'b1;
            if (redirect_valid) begin
                pc       <= {redirect_pc[XLEN-1:2], 2'b00};
                inflight <= 1'b0;
                killed   <= 1'b1;
            end else if (imem_req) begin
                pc       <= pc + XLEN'(INSTR_BYTES);
                req_pc   <= pc;
                inflight <= 1'b1;
                killed   <= 1'b0;
            end else begin
                inflight <= 1'b0;
                killed   <= 1'b0;
            end
        end
    end

    fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (redirect_valid),
        .head      (head_entry),
        .valid     (out_valid),
        .count     (occupancy)
    );
endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit; imem model returns word == address.
module tb_fetch_queue_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [2:0]  occupancy;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_pc;

    fetch_queue_unit #(.XLEN(32), .DEPTH(4), .PC_RESET(32'h0)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .occupancy      (occupancy)
    );

    always #5 clk = ~clk;

    // Synchronous memory; idle cycles drive a poison word.
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= imem_addr;
        else          imem_rdata <= 32'hBAD0_0BAD;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_out_valid"}, 32'(out_valid), 32'h0);
        check({tag, "_out_instr"}, out_instr, 32'h0);
        check({tag, "_out_pc"},    out_pc, 32'h0);
        check({tag, "_occupancy"}, 32'(occupancy), 32'h0);
        check({tag, "_imem_req"},  32'(imem_req), 32'h0);
        check({tag, "_imem_addr"}, imem_addr, 32'h0);
    endtask

    // Every accepted entry must continue the sequence from start; nothing else may appear.
    task automatic expect_stream(input logic [31:0] start, input int n, input string tag);
        int got = 0;
        exp_pc = start;
        for (int c = 0; c < 40 && got < n; c++) begin
            if (out_valid && out_ready) begin
                check({tag, "_pc"},    out_pc, exp_pc);
                check({tag, "_instr"}, out_instr, exp_pc);
                exp_pc = exp_pc + 32'd4;
                got++;
            end
            tick();
        end
        checks++;
        assert (got == n) else begin
            errors++;
            $error("FAIL %s_count observed %0d expected %0d", tag, got, n);
        end
    endtask

    initial begin
        int          nreq;
        logic [31:0] last_addr;

        // Reset state
        repeat (3) tick();
        check_reset_state("reset");

        // Free-running stream from PC_RESET
        out_ready = 1'b1;
        rst = 1'b1;
        tick();
        check("t1_first_req",  32'(imem_req), 32'h1);
        check("t1_first_addr", imem_addr, 32'h0);
        check("t1_valid_early", 32'(out_valid), 32'h0);
        tick();
        check("t1_addr_1", imem_addr, 32'h4);
        check("t1_valid_n1", 32'(out_valid), 32'h0);
        tick();
        check("t1_valid_n2", 32'(out_valid), 32'h1);
        check("t1_occ", 32'(occupancy), 32'h1);
        check("t1_addr_2", imem_addr, 32'h8);
        expect_stream(32'h0, 6, "t1_stream");

        // Decode stalled from reset: credit caps requests at DEPTH
        rst = 1'b0;
        tick();
        out_ready = 1'b0;
        rst = 1'b1;
        nreq = 0;
        last_addr = 32'hFFFF_FFFF;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (imem_req) begin
                nreq++;
                last_addr = imem_addr;
            end
        end
        check("t2_nreq", 32'(nreq), 32'd4);
        check("t2_last_addr", last_addr, 32'hC);
        check("t2_occ_full", 32'(occupancy), 32'h4);
        check("t2_req_blocked", 32'(imem_req), 32'h0);
        out_ready = 1'b1;
        expect_stream(32'h0, 6, "t2_drain");

        // Redirect with 3 queued and 1 in flight
        rst = 1'b0;
        tick();
        out_ready = 1'b0;
        rst = 1'b1;
        repeat (5) tick();
        check("t3_occ_before", 32'(occupancy), 32'h3);
        check("t3_no_credit", 32'(imem_req), 32'h0);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0103;
        tick();
        check("t3_occ_flushed", 32'(occupancy), 32'h0);
        check("t3_valid_flushed", 32'(out_valid), 32'h0);
        check("t3_addr", imem_addr, 32'h100);
        check("t3_req_during_redirect", 32'(imem_req), 32'h0);
        redirect_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        check("t3_req_resume", 32'(imem_req), 32'h1);
        tick();
        check("t3_valid_n1", 32'(out_valid), 32'h0);
        tick();
        check("t3_valid_n2", 32'(out_valid), 32'h1);
        expect_stream(32'h100, 4, "t3_stream");

        // Redirect in the same cycle as a pop
        check("t4_pop_valid", 32'(out_valid), 32'h1);
        check("t4_pop_pc", out_pc, exp_pc);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0200;
        tick();
        check("t4_occ_flushed", 32'(occupancy), 32'h0);
        check("t4_addr", imem_addr, 32'h200);
        redirect_valid = 1'b0;
        expect_stream(32'h200, 3, "t4_stream");

        // Address wrap at the top of memory
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        tick();
        check("t5_addr", imem_addr, 32'hFFFF_FFF8);
        redirect_valid = 1'b0;
        expect_stream(32'hFFFF_FFF8, 4, "t5_wrap");

        // Asynchronous reset with a request in flight
        check("t6_streaming", 32'(out_valid), 32'h1);
        rst = 1'b0;
        #1;
        check_reset_state("t6_async");
        tick();
        tick();
        rst = 1'b1;
        expect_stream(32'h0, 3, "t6_restart");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
